// File: rtl/data_ram_hs.sv
// data_ram_hs: byte-lane data RAM with a ce/ready handshake and a fixed
// number of wait states. One request is in flight at a time. The write commit
// and the read return both happen on the edge that enters RESP.
// Optional feature macro: DATA_RAM_ERR_EN. When it is defined, an address above
// the RAM depth is flagged on err. When it is undefined, err is 0 and the
// address wraps.
module data_ram_hs #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 15,
  parameter int WAIT_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [DATA_W/8-1:0]   sel,
  input  logic [DATA_W-1:0]     data_i,
  output logic [DATA_W-1:0]     data_o,
  output logic                  busy,
  output logic                  ready,
  output logic                  err
);
  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t state, next_state;
  logic [3:0] cnt;

  // captured request
  logic              req_we;
  logic [ADDR_W-1:0] req_idx;
  logic [LANES-1:0]  req_sel;
  logic [DATA_W-1:0] req_data;
  logic              req_err;

  // request seen at the access edge
  logic              accept, access;
  logic              acc_we, acc_err, in_err;
  logic [ADDR_W-1:0] acc_idx;
  logic [LANES-1:0]  acc_sel;
  logic [DATA_W-1:0] acc_data;

  logic [LANES-1:0][7:0] mem [DEPTH];

`ifdef DATA_RAM_ERR_EN
  assign in_err = |addr[31:ADDR_W+2];
  logic unused_addr;
  assign unused_addr = &{1'b0, addr[1:0]};
`else
  assign in_err = 1'b0;
  logic unused_addr;
  assign unused_addr = &{1'b0, addr[31:ADDR_W+2], addr[1:0], req_err};
`endif

  assign accept = (state == S_IDLE) && ce;
  // The access edge is the edge that enters RESP. With WAIT_CYC=0 this is the
  // accept edge itself, so the live inputs are used instead of the captured copy.
  assign access = (next_state == S_RESP) && (state != S_RESP);

  assign acc_we   = (state == S_IDLE) ? we                : req_we;
  assign acc_idx  = (state == S_IDLE) ? addr[ADDR_W+1:2]  : req_idx;
  assign acc_sel  = (state == S_IDLE) ? sel               : req_sel;
  assign acc_data = (state == S_IDLE) ? data_i            : req_data;
  assign acc_err  = (state == S_IDLE) ? in_err            : req_err;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (ce) next_state = (WAIT_CYC == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == 4'd1) next_state = S_RESP;
      S_RESP: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // handshake outputs
  always_comb begin
    busy  = (state != S_IDLE);
    ready = (state == S_RESP);
  end

  // wait-state counter
  always_ff @(posedge clk) begin
    if (rst)                 cnt <= 4'd0;
    else if (accept)         cnt <= WAIT_INIT;
    else if (state == S_WAIT) cnt <= cnt - 4'd1;
  end

  // request capture on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      req_we   <= 1'b0;
      req_idx  <= '0;
      req_sel  <= '0;
      req_data <= '0;
      req_err  <= 1'b0;
    end else if (accept) begin
      req_we   <= we;
      req_idx  <= addr[ADDR_W+1:2];
      req_sel  <= sel;
      req_data <= data_i;
      req_err  <= in_err;
    end
  end

  // read-data register; writes and range errors return zero
  always_ff @(posedge clk) begin
    if (rst)                      data_o <= '0;
    else if (access) begin
      if (acc_we || acc_err)      data_o <= '0;
      else                        data_o <= mem[acc_idx];
    end
  end

`ifdef DATA_RAM_ERR_EN
  // error flag: cleared on accept, set at the access edge of an out-of-range request
  always_ff @(posedge clk) begin
    if (rst)                      err <= 1'b0;
    else if (access && acc_err)   err <= 1'b1;
    else if (accept)              err <= 1'b0;
  end
`else
  assign err = 1'b0;
`endif

  // byte-lane write commit; dropped if reset lands on the access edge
  always_ff @(posedge clk) begin
    if (access && !rst && acc_we && !acc_err) begin
      for (int i = 0; i < LANES; i++)
        if (acc_sel[i]) mem[acc_idx][i] <= acc_data[8*i +: 8];
    end
  end

endmodule
